// File: rtl/alu181_pkg.sv
// Shared types, named function selects and the bit-level 74181 equations
// used by the slice and by the pipeline's overflow logic.
package alu181_pkg;

    typedef logic [3:0] sel_t;

    typedef enum logic {
        MODE_ARITH = 1'b0,
        MODE_LOGIC = 1'b1
    } mode_t;

    // Arithmetic selects (m = 0)
    localparam sel_t S_PASS   = 4'd0;
    localparam sel_t S_SUB    = 4'd6;
    localparam sel_t S_ADD    = 4'd9;
    localparam sel_t S_DOUBLE = 4'd12;
    localparam sel_t S_DEC    = 4'd15;

    // Logic selects (m = 1)
    localparam sel_t S_NOT_A  = 4'd0;
    localparam sel_t S_ZERO   = 4'd3;
    localparam sel_t S_XOR    = 4'd6;
    localparam sel_t S_XNOR   = 4'd9;
    localparam sel_t S_B      = 4'd10;
    localparam sel_t S_AND    = 4'd11;
    localparam sel_t S_ONES   = 4'd12;
    localparam sel_t S_OR     = 4'd14;
    localparam sel_t S_A      = 4'd15;

    // Arithmetic result is term_p + term_g + carry, bit by bit.
    function automatic logic term_p(input sel_t s, input logic a, input logic b);
        return a | (b & s[0]) | (~b & s[1]);
    endfunction

    function automatic logic term_g(input sel_t s, input logic a, input logic b);
        return (a & b & s[3]) | (a & ~b & s[2]);
    endfunction

    function automatic logic [3:0] logic_op(input sel_t s, input logic [3:0] a,
                                            input logic [3:0] b);
        logic [3:0] r;
        r = '0;
        case (s)
            4'd0:    r = ~a;
            4'd1:    r = ~(a | b);
            4'd2:    r = ~a & b;
            4'd3:    r = 4'h0;
            4'd4:    r = ~(a & b);
            4'd5:    r = ~b;
            4'd6:    r = a ^ b;
            4'd7:    r = a & ~b;
            4'd8:    r = ~a | b;
            4'd9:    r = ~(a ^ b);
            4'd10:   r = b;
            4'd11:   r = a & b;
            4'd12:   r = 4'hF;
            4'd13:   r = a | ~b;
            4'd14:   r = a | b;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 slice: logic result plus the arithmetic sum of
// its two slice terms and the ripple carry.
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [3:0] s,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] logic_f,
    output logic [3:0] sum,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;

    always_comb begin
        p = '0;
        g = '0;
        for (int i = 0; i < 4; i++) begin
            p[i] = term_p(s, a[i], b[i]);
            g[i] = term_g(s, a[i], b[i]);
        end
    end

    assign {co, sum} = {1'b0, p} + {1'b0, g} + {4'b0000, ci};
    assign logic_f   = logic_op(s, a, b);

endmodule

// File: rtl/alu181_pipe.sv
// Two-stage valid/ready 74181-style ALU over WIDTH bits with registered
// result/flags and a stored carry for multi-word arithmetic chains.
module alu181_pipe
    import alu181_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    input  logic             cin_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             eq,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;

    if ((WIDTH < 4) || (WIDTH % 4 != 0)) begin : g_width_check
        $error("alu181_pipe: WIDTH must be a multiple of 4 and at least 4");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Stage 2 moves when it is empty or being drained; stage 1 may accept
    // when it is empty or moving into stage 2 (no skid buffer).
    logic             advance;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    sel_t             s1_s;
    mode_t            s1_m;
    logic             s1_cin;
    logic             s1_cin_sel;
    logic             carry_q;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    logic [NSLICE:0]  chain;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] arith_res;

    // Carry source is resolved at the S1->S2 move so a chained op sees the
    // carry of the arithmetic op directly ahead of it.
    assign chain[0] = s1_cin_sel ? carry_q : s1_cin;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        alu181_slice u_slice (
            .s       (s1_s),
            .a       (s1_a[4*i +: 4]),
            .b       (s1_b[4*i +: 4]),
            .ci      (chain[i]),
            .logic_f (logic_res[4*i +: 4]),
            .sum     (arith_res[4*i +: 4]),
            .co      (chain[i+1])
        );
    end

    logic             is_logic;
    logic             msb_carry;
    logic [WIDTH-1:0] f_next;
    logic             cout_next;
    logic             ovf_next;

    always_comb begin
        is_logic  = (s1_m == MODE_LOGIC);
        msb_carry = arith_res[WIDTH-1]
                  ^ term_p(s1_s, s1_a[WIDTH-1], s1_b[WIDTH-1])
                  ^ term_g(s1_s, s1_a[WIDTH-1], s1_b[WIDTH-1]);
        f_next    = is_logic ? logic_res : arith_res;
        cout_next = !is_logic && chain[NSLICE];
        ovf_next  = !is_logic && (msb_carry ^ chain[NSLICE]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_s       <= '0;
            s1_m       <= MODE_ARITH;
            s1_cin     <= 1'b0;
            s1_cin_sel <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a       <= a;
                s1_b       <= b;
                s1_s       <= s;
                s1_m       <= mode_t'(m);
                s1_cin     <= cin;
                s1_cin_sel <= cin_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            eq        <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            carry_q   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f    <= f_next;
                cout <= cout_next;
                eq   <= &f_next;
                zero <= ~|f_next;
                ovf  <= ovf_next;
                if (!is_logic) begin
                    carry_q <= cout_next;
                end
            end
        end
    end

endmodule
